// File: rtl/alu_defs.sv
// Shared ALU operation encodings; ALU control imports this same package.
package alu_defs;

  localparam int unsigned AluWidth = 32;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluNot = 4'b0010;
  localparam logic [3:0] AluSl  = 4'b0011;
  localparam logic [3:0] AluSr  = 4'b0100;
  localparam logic [3:0] AluAnd = 4'b0101;
  localparam logic [3:0] AluOr  = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluMul = 4'b1000;
  localparam logic [3:0] AluDiv = 4'b1001;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative signed multiply / restoring divide: one bit per cycle on operand magnitudes,
// with sign correction applied combinationally on the outputs.
module mul_div_iter
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             finish
);

  localparam int unsigned CntW = $clog2(WIDTH);

  // acc_q holds {hi, lo} of the product for MUL and {remainder, quotient} for DIV
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q;
  logic [CntW-1:0]    cnt_q;
  logic               active_q, div_q, quo_neg_q, rem_neg_q, b_zero_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, rem_sh, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign finish = active_q && (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    if (!div_q) begin
      acc_d = {add_sum, acc_q[WIDTH-1:1]};
    end else if (trial[WIDTH]) begin
      acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      div_q     <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else if (load) begin
      acc_q     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
      dvs_q     <= is_div ? b_mag : a_mag;
      cnt_q     <= '0;
      active_q  <= 1'b1;
      div_q     <= is_div;
      quo_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      rem_neg_q <= a[WIDTH-1];
      b_zero_q  <= (b == '0);
    end else if (active_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (finish) active_q <= 1'b0;
    end
  end

  always_comb begin
    prod = quo_neg_q ? (~acc_q + 1'b1) : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      // Divide by zero yields all-ones; the remainder path already reproduces a
      lo = b_zero_q ? '1 : (quo_neg_q ? (~quo + 1'b1) : quo);
      hi = rem_neg_q ? (~rem + 1'b1) : rem;
    end else begin
      lo = prod[WIDTH-1:0];
      hi = prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/shift/add ops plus iterative MUL/DIV with
// a start/done handshake and busy stall.
module multicycle_alu
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_cnt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned ShW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, hi_q, single_res, iter_lo, iter_hi;
  logic             zero_q, done_q, load, wr_single, wr_iter, iter_finish, is_multi;
  logic [ShW-1:0]   shamt;

  assign shamt    = b[ShW-1:0];
  assign is_multi = (alu_cnt == AluMul) || (alu_cnt == AluDiv);

  always_comb begin
    single_res = '0;
    case (alu_cnt)
      AluAdd:  single_res = a + b;
      AluSub:  single_res = a - b;
      AluNot:  single_res = ~a;
      AluSl:   single_res = a << shamt;
      AluSr:   single_res = a >> shamt;
      AluAnd:  single_res = a & b;
      AluOr:   single_res = a | b;
      AluSlt:  single_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: single_res = '0;
    endcase
  end

  mul_div_iter #(
    .WIDTH(WIDTH)
  ) u_mul_div_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .is_div (alu_cnt == AluDiv),
    .a      (a),
    .b      (b),
    .lo     (iter_lo),
    .hi     (iter_hi),
    .finish (iter_finish)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    wr_single = 1'b0;
    wr_iter   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_multi) begin
            load    = 1'b1;
            state_d = StIter;
          end else begin
            wr_single = 1'b1;
          end
        end
      end
      StIter: if (iter_finish) state_d = StFix;
      StFix: begin
        wr_iter = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= wr_single | wr_iter;
      if (wr_single) begin
        result_q <= single_res;
        zero_q   <= (single_res == '0);
      end else if (wr_iter) begin
        result_q <= iter_lo;
        hi_q     <= iter_hi;
        zero_q   <= (iter_lo == '0);
      end
    end
  end

  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = zero_q;
  assign done   = done_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against a plain-arithmetic model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_cnt = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result, hi;
  logic        zero, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] hi_m = '0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .alu_cnt (alu_cnt),
    .a       (a),
    .b       (b),
    .result  (result),
    .hi      (hi),
    .zero    (zero),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] h_prev, output logic [31:0] r,
                                 output logic [31:0] h);
    longint sx, sy, p, q, rm;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h  = h_prev;
    r  = '0;
    case (op)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = ~x;
      4'd3: r = x << y[4:0];
      4'd4: r = x >> y[4:0];
      4'd5: r = x & y;
      4'd6: r = x | y;
      4'd7: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8: begin
        p = sx * sy;
        r = p[31:0];
        h = p[63:32];
      end
      4'd9: begin
        if (y == 0) begin
          r = 32'hFFFF_FFFF;
          h = x;
        end else begin
          q  = sx / sy;
          rm = sx % sy;
          r  = q[31:0];
          h  = rm[31:0];
        end
      end
      default: r = '0;
    endcase
  endfunction

  // Called at a negedge; start is sampled at the following posedge (cycle 0).
  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    logic [31:0] er, eh;
    logic        multi, busy_ok;
    int          cyc;
    multi = (op == 4'd8) || (op == 4'd9);
    ref_op(op, x, y, hi_m, er, eh);
    hi_m    = eh;
    start   = 1'b1;
    alu_cnt = op;
    a       = x;
    b       = y;
    @(negedge clk);
    start   = 1'b0;
    alu_cnt = 4'($urandom);
    a       = $urandom;
    b       = $urandom;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 60) begin
      if (busy !== (multi && cyc <= 33)) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, multi ? 32'd34 : 32'd1);
    check({tag, " busy"}, {31'd0, busy_ok && !busy}, 32'd1);
    check({tag, " result"}, result, er);
    check({tag, " hi"}, hi, eh);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, er == 0});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edges [5];
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    if ($urandom_range(0, 1) == 0) return 32'($signed(16'($urandom)));
    return $urandom;
  endfunction

  initial begin
    logic [31:0] er, eh;
    logic [3:0]  op;
    logic        ok;

    #12;
    check("reset result", result, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset zero/busy/done", {29'd0, zero, busy, done}, 32'h4);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(4'd0, 32'h7FFF_FFFF, 32'd1, "add ovf");
    do_op(4'd1, 32'd5, 32'd5, "sub zero");
    do_op(4'd7, 32'hFFFF_FFFF, 32'd1, "slt");
    do_op(4'd3, 32'd1, 32'h3F, "sl");
    do_op(4'd4, 32'h8000_0000, 32'd31, "sr");
    do_op(4'd2, 32'd0, 32'd0, "not");
    do_op(4'd8, 32'hFFFF_FFFD, 32'd7, "mul neg");
    do_op(4'd9, -32'sd7, 32'd2, "div neg");
    do_op(4'd9, 32'd9, 32'd0, "div zero");
    do_op(4'd9, -32'sd9, 32'd0, "div zero neg");
    do_op(4'd9, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    do_op(4'd15, 32'd3, 32'd4, "undef");

    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 11)), pick(), pick(), "rand");
    end

    // One single-cycle op per cycle with start held high.
    for (int i = 0; i < 8; i++) begin
      op      = 4'($urandom_range(0, 7));
      start   = 1'b1;
      alu_cnt = op;
      a       = pick();
      b       = pick();
      ref_op(op, a, b, hi_m, er, eh);
      @(negedge clk);
      check("b2b result", result, er);
      check("b2b done", {31'd0, done}, 32'd1);
    end
    start = 1'b0;
    @(negedge clk);

    // Start during MUL is ignored, then reset aborts the MUL.
    start = 1'b1; alu_cnt = 4'd8; a = 32'd5; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; alu_cnt = 4'd0; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b1;
    for (int c = 6; c < 10; c++) begin
      if (done !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    check("start ignored while busy", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort result", result, 32'h0);
    check("abort hi", hi, 32'h0);
    check("abort zero/busy/done", {29'd0, zero, busy, done}, 32'h4);
    @(negedge clk);
    rst  = 1'b0;
    hi_m = '0;
    ok   = 1'b1;
    repeat (40) begin
      if (done !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("no done after abort", {31'd0, ok}, 32'd1);
    do_op(4'd0, 32'd2, 32'd3, "add after reset");
    do_op(4'd8, pick(), pick(), "mul then single");
    do_op(4'd5, pick(), pick(), "single after mul");
    @(negedge clk);
    check("done one pulse", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Execute-stage ALU for the MIPS datapath: consumes the 4-bit `alu_cnt` operation code produced by ALU control and performs the operation on two register operands. Logic, shift, add/sub and SLT ops complete in one cycle. MUL and DIV run on an iterative shift/add (restoring) engine, and the block holds the pipeline via `busy`. A `start`/`done` handshake lets the control FSM stall until the result is valid.

## Interface
- `WIDTH`, 32, operand/result width (power of two, ≥8)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `alu_cnt`  in  4  operation code: 0000 ADD, 0001 SUB, 0010 NOT, 0011 SL, 0100 SR, 0101 AND, 0110 OR, 0111 SLT, 1000 MUL, 1001 DIV
- `a`, `b`  in  WIDTH  operands, sampled with `start`
- `result`  out  WIDTH  registered primary result (low product / quotient)
- `hi`  out  WIDTH  registered high product / remainder
- `zero`  out  1  registered, `result == 0`
- `busy`  out  1  iterative op in flight
- `done`  out  1  one-cycle pulse; `result`/`hi`/`zero` valid from this cycle until the next write

## Operation
- States: IDLE, ITER, FIX.
- IDLE + `start`, single-cycle op: compute, write `result`/`zero`, pulse `done` next cycle; `hi` unchanged; stay IDLE.
- IDLE + `start`, MUL/DIV: latch operand magnitudes and sign flags, clear the iteration counter, go to ITER.
- ITER: one bit per cycle for WIDTH cycles.
  - MUL: shift-add.
  - DIV: restoring subtract.
  - On the counter reaching WIDTH-1, go to FIX.
- FIX: apply sign correction, write `result`/`hi`/`zero`, go to IDLE; `done` is high the following cycle.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - NOT = ~a.
  - SL and SR are logical shifts by `b[log2(WIDTH)-1:0]`; upper bits of `b` are ignored.
  - SLT is a signed compare: result = 1 or 0, zero-extended.
- MUL: signed 2·WIDTH-bit product; `hi` = upper half, `result` = lower half.
- DIV: signed, truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Quotient goes to `result`, remainder to `hi`.
- DIV by zero: `result` = all-ones, `hi` = `a`; same latency, no fault.
- DIV of most-negative by −1: `result` = 0x80000000 (for WIDTH 32), `hi` = 0.
- Undefined `alu_cnt` (1010–1111): `result` = 0, `zero` = 1, `done` pulses after 1 cycle; `hi` unchanged.
- `start` while `busy` is ignored: no queueing, no effect on the in-flight op.
- `start` in the same cycle `done` is high is accepted, since the state is IDLE.
- Operand changes after acceptance have no effect.

## Timing
- Count the cycle in which `start` is sampled high as cycle 0.
- Single-cycle ops: `done` high in cycle 1; `busy` never asserts.
- MUL/DIV:
  - `busy` is high in cycles 1..WIDTH+1.
  - `done` is high in cycle WIDTH+2 (cycle 34 for WIDTH 32), with `busy` low.
- Back-to-back throughput: one single-cycle op per cycle.
- Reset values: `result` = 0, `hi` = 0, `zero` = 1, `busy` = 0, `done` = 0, state IDLE, counter 0.
- Reset mid-operation aborts immediately (asynchronously): the partial result is discarded and no `done` pulse is produced.

## Structure
- Shared package `alu_defs`: the ten `alu_cnt` code constants and the WIDTH default. ALU control imports the same package so the encodings cannot drift.
- State encoding is local to this block.
- Sub-module `mul_div_iter`: holds the magnitude/sign latch, the iteration counter, the shift-add and restoring datapath, and the FIX sign correction.
  - Interface: load, is_div, a, b → lo, hi, finish.
- The top level holds the single-cycle combinational ops, the output registers and the FSM.

## Test plan
All cases at WIDTH 32.
- ADD a=0x7FFFFFFF, b=1 → `result` 0x80000000, `zero` 0, `done` in cycle 1. SUB a=5, b=5 → `result` 0, `zero` 1.
- SLT a=0xFFFFFFFF, b=1 → 1. SL a=1, b=0x3F → 0x80000000. SR a=0x80000000, b=31 → 1. NOT a=0 → 0xFFFFFFFF.
- MUL a=0xFFFFFFFD (−3), b=7 → `result` 0xFFFFFFEB, `hi` 0xFFFFFFFF; `busy` high in cycles 1–33, `done` in cycle 34 only.
- DIV a=−7, b=2 → `result` 0xFFFFFFFD, `hi` 0xFFFFFFFF. DIV a=9, b=0 → `result` 0xFFFFFFFF, `hi` 9. DIV 0x80000000 by 0xFFFFFFFF → `result` 0x80000000, `hi` 0.
- During MUL, pulse `start` with ADD in cycle 5 → ignored; then assert `rst` in cycle 10 → all outputs at reset values, no `done`; a following ADD 2+3 → 5 in 1 cycle.
- `alu_cnt` = 1111 → `result` 0, `zero` 1, `hi` unchanged, `done` in cycle 1.
